sf_camera_frame_ctrl: RTL and testbench
=======================================

Name: sf_camera_frame_ctrl

Overview:
System-clock-side capture controller for the SF camera path. Sequences a frame capture:
- optional timed camera reset
- drains camera ping-pong FIFO blocks through the ppfifo read side
- writes each dword to a memory write port at incrementing addresses
- counts dwords per frame and pulses frame-done (single-shot or continuous).

Parameters:
CAM_RST_CYCLES, 1000, clk cycles o_cam_rst held high per reset request
ADDR_STEP, 4, byte increment of o_mem_addr per dword
COUNT_WIDTH, 24, width of frame/block dword counters (matches FIFO size width)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
i_start  in  1  pulse: begin capture at i_frame_base
i_abort  in  1  pulse: stop capture
i_continuous  in  1  sampled at start: 1 = restart after each frame
i_cam_rst_req  in  1  pulse: issue timed camera reset (accepted only in IDLE)
i_frame_base  in  32  frame base byte address, latched at start
i_frame_dwords  in  COUNT_WIDTH  dwords per frame, latched at start
o_cam_rst  out  1  camera reset output
i_fifo_ready  in  1  ppfifo read block available
o_fifo_activate  out  1  ppfifo read block claim
i_fifo_size  in  COUNT_WIDTH  dwords in claimed block, valid while activated
o_fifo_strobe  out  1  consume current dword
i_fifo_data  in  32  current dword (first-word fall-through while activated)
o_mem_addr  out  32  write address
o_mem_data  out  32  write data
o_mem_stb  out  1  write request, held until ack
i_mem_ack  in  1  write accepted
o_busy  out  1  capture in progress
o_frame_done  out  1  one-cycle pulse per completed frame
o_overflow  out  1  sticky: block held dwords beyond frame end; cleared by i_start
o_dword_count  out  COUNT_WIDTH  dwords written in current frame

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; counters and latched config 0.

States:
- IDLE:
  - i_cam_rst_req -> CAM_RST.
  - i_start with latched i_frame_dwords != 0 -> WAIT_BLK. Latch base, size and continuous; clear o_dword_count and o_overflow; o_busy=1.
  - i_start with i_frame_dwords==0 is ignored.
- CAM_RST:
  - o_cam_rst=1 for exactly CAM_RST_CYCLES cycles, then IDLE.
  - i_start is ignored in this state.
- WAIT_BLK: when i_fifo_ready && !o_fifo_activate, set o_fifo_activate=1 -> LOAD.
- LOAD:
  - One cycle; latch i_fifo_size into the block counter.
  - Size 0 -> RELEASE; else -> WRITE.
- WRITE:
  - o_mem_stb=1 with o_mem_addr = base + ADDR_STEP*o_dword_count and o_mem_data = i_fifo_data.
  - Addr/data stay stable until the ack cycle.
  - On i_mem_ack: o_fifo_strobe=1 for that cycle; o_mem_stb drops the next cycle; block counter -1; o_dword_count +1 -> NEXT.
- NEXT:
  - o_dword_count == frame size: if block counter != 0 -> DRAIN; else -> RELEASE and frame complete.
  - Else: block counter 0 -> RELEASE; else -> WRITE.
  - Throughput: max one dword per 2 cycles.
- DRAIN:
  - Set o_overflow.
  - Strobe one dword per cycle, no memory write, until block counter 0 -> RELEASE.
- RELEASE:
  - o_fifo_activate=0 for at least one cycle.
  - Frame complete -> DONE; else -> WAIT_BLK.
- DONE:
  - o_frame_done=1 for one cycle.
  - Continuous: clear o_dword_count -> WAIT_BLK, o_busy stays 1.
  - Otherwise -> IDLE, o_busy=0.

Abort:
- i_abort in WAIT_BLK/LOAD/NEXT -> RELEASE with abort flag.
- i_abort in WRITE is held pending until ack completes.
- Abort during DRAIN finishes the drain.
- After abort, RELEASE -> IDLE with no o_frame_done.
- i_abort and i_start in the same cycle: abort wins, start ignored.
- i_start while o_busy is ignored.

Arithmetic: address add wraps modulo 2^32; counters never exceed frame size.

Reset mid-operation: state and outputs return to reset values next cycle. The FIFO block is abandoned (ppfifo shares rst).

Decomposition:
- Shared package sf_camera_pkg holds:
  - state enum
  - COUNT_WIDTH
  - default CAM_RST_CYCLES
  - control-register bit indices (start/abort/continuous/cam_rst), shared with the register block.
- One natural sub-module: sf_cam_rst_timer, a CAM_RST_CYCLES down-counter with request/active/done.

Test Plan:
1. Frame of 8 dwords, base 0x1000, one 8-dword block, ack next cycle -> addrs 0x1000..0x101C with matching data; 8 strobes; o_frame_done once; o_busy falls after DONE.
2. Frame of 6, blocks of 4 then 4 -> 6 writes, 2 drained dwords, o_overflow=1, o_dword_count=6, activate deasserted between blocks.
3. Continuous, frame of 4, three blocks of 4 -> three o_frame_done pulses; addresses restart at base each frame; o_busy stays 1.
4. i_mem_ack delayed 5 cycles -> o_mem_stb/addr/data stable 5 cycles; exactly one o_fifo_strobe, on the ack cycle.
5. i_abort during pending WRITE -> write completes, activate drops, IDLE, no o_frame_done; simultaneous i_start+i_abort in IDLE -> stays IDLE.
6. i_cam_rst_req with CAM_RST_CYCLES=10 -> o_cam_rst high exactly 10 cycles; i_start during it ignored.

Source files
------------

// File: rtl/sf_camera_pkg.sv
// Shared definitions for the SF camera capture path: FSM encodings, counter
// width, camera reset timing and control-register bit positions.
package sf_camera_pkg;

    localparam int COUNT_WIDTH            = 24;
    localparam int DEFAULT_CAM_RST_CYCLES = 1000;

    // Control-register bit positions, shared with the register block
    localparam int CTRL_START_BIT      = 0;
    localparam int CTRL_ABORT_BIT      = 1;
    localparam int CTRL_CONTINUOUS_BIT = 2;
    localparam int CTRL_CAM_RST_BIT    = 3;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_CAM_RST  = 4'd1;
    localparam state_t ST_WAIT_BLK = 4'd2;
    localparam state_t ST_LOAD     = 4'd3;
    localparam state_t ST_WRITE    = 4'd4;
    localparam state_t ST_NEXT     = 4'd5;
    localparam state_t ST_DRAIN    = 4'd6;
    localparam state_t ST_RELEASE  = 4'd7;
    localparam state_t ST_DONE     = 4'd8;

endpackage

// File: rtl/sf_cam_rst_timer.sv
// Timed camera reset: once requested, active stays high for exactly CYCLES
// clocks, followed by a one-cycle done pulse.
module sf_cam_rst_timer
    import sf_camera_pkg::*;
#(
    parameter int CYCLES = DEFAULT_CAM_RST_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic active,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // The count is loaded with CYCLES-1 so that active covers exactly CYCLES clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (req) begin
                    active <= 1'b1;
                    count  <= CW'(CYCLES - 1);
                end
            end else if (count == '0) begin
                active <= 1'b0;
                done   <= 1'b1;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sf_camera_frame_ctrl.sv
// Frame capture sequencer: claims ppfifo read blocks, writes each dword to
// memory at incrementing addresses and signals completed frames.
module sf_camera_frame_ctrl #(
    parameter int CAM_RST_CYCLES = sf_camera_pkg::DEFAULT_CAM_RST_CYCLES,
    parameter int ADDR_STEP      = 4,
    parameter int COUNT_WIDTH    = sf_camera_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_continuous,
    input  logic                   i_cam_rst_req,
    input  logic [31:0]            i_frame_base,
    input  logic [COUNT_WIDTH-1:0] i_frame_dwords,
    output logic                   o_cam_rst,
    input  logic                   i_fifo_ready,
    output logic                   o_fifo_activate,
    input  logic [COUNT_WIDTH-1:0] i_fifo_size,
    output logic                   o_fifo_strobe,
    input  logic [31:0]            i_fifo_data,
    output logic [31:0]            o_mem_addr,
    output logic [31:0]            o_mem_data,
    output logic                   o_mem_stb,
    input  logic                   i_mem_ack,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_overflow,
    output logic [COUNT_WIDTH-1:0] o_dword_count
);

    import sf_camera_pkg::*;

    state_t                 state;
    logic [31:0]            base_addr;
    logic [31:0]            cur_addr;
    logic [COUNT_WIDTH-1:0] frame_dwords;
    logic [COUNT_WIDTH-1:0] block_count;
    logic [COUNT_WIDTH-1:0] dword_count;
    logic                   continuous;
    logic                   abort_flag;
    logic                   frame_complete;
    logic                   activate;
    logic                   overflow;
    logic                   cam_rst_active;
    logic                   cam_rst_done;
    logic                   abort_now;

    assign abort_now = i_abort | abort_flag;

    sf_cam_rst_timer #(
        .CYCLES (CAM_RST_CYCLES)
    ) u_cam_rst_timer (
        .clk    (clk),
        .rst    (rst),
        .req    ((state == ST_IDLE) && i_cam_rst_req),
        .active (cam_rst_active),
        .done   (cam_rst_done)
    );

    // cur_addr tracks base + ADDR_STEP*dword_count incrementally, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            base_addr      <= '0;
            cur_addr       <= '0;
            frame_dwords   <= '0;
            block_count    <= '0;
            dword_count    <= '0;
            continuous     <= 1'b0;
            abort_flag     <= 1'b0;
            frame_complete <= 1'b0;
            activate       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_cam_rst_req) begin
                        state <= ST_CAM_RST;
                    end else if (i_start && !i_abort && (i_frame_dwords != '0)) begin
                        base_addr      <= i_frame_base;
                        cur_addr       <= i_frame_base;
                        frame_dwords   <= i_frame_dwords;
                        continuous     <= i_continuous;
                        dword_count    <= '0;
                        overflow       <= 1'b0;
                        abort_flag     <= 1'b0;
                        frame_complete <= 1'b0;
                        state          <= ST_WAIT_BLK;
                    end
                end
                ST_CAM_RST: begin
                    if (cam_rst_done) state <= ST_IDLE;
                end
                ST_WAIT_BLK: begin
                    if (abort_now) begin
                        abort_flag <= 1'b1;
                        state      <= ST_RELEASE;
                    end else if (i_fifo_ready && !activate) begin
                        activate <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort_now) begin
                        abort_flag <= 1'b1;
                        state      <= ST_RELEASE;
                    end else begin
                        block_count <= i_fifo_size;
                        state       <= (i_fifo_size == '0) ? ST_RELEASE : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_abort) abort_flag <= 1'b1;
                    if (i_mem_ack) begin
                        block_count <= block_count - COUNT_WIDTH'(1);
                        dword_count <= dword_count + COUNT_WIDTH'(1);
                        cur_addr    <= cur_addr + 32'(ADDR_STEP);
                        state       <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (abort_now) begin
                        abort_flag <= 1'b1;
                        state      <= ST_RELEASE;
                    end else if (dword_count == frame_dwords) begin
                        frame_complete <= 1'b1;
                        if (block_count != '0) begin
                            overflow <= 1'b1;
                            state    <= ST_DRAIN;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else if (block_count == '0) begin
                        state <= ST_RELEASE;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_DRAIN: begin
                    if (i_abort) abort_flag <= 1'b1;
                    block_count <= block_count - COUNT_WIDTH'(1);
                    if (block_count == COUNT_WIDTH'(1)) state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    activate <= 1'b0;
                    if (abort_now) begin
                        abort_flag <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (frame_complete) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_BLK;
                    end
                end
                ST_DONE: begin
                    if (continuous && !abort_now) begin
                        dword_count    <= '0;
                        cur_addr       <= base_addr;
                        frame_complete <= 1'b0;
                        state          <= ST_WAIT_BLK;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address and data are forced to zero outside a write so idle outputs read 0
    always_comb begin
        o_mem_stb     = (state == ST_WRITE);
        o_mem_addr    = o_mem_stb ? cur_addr : 32'h0;
        o_mem_data    = o_mem_stb ? i_fifo_data : 32'h0;
        o_fifo_strobe = (o_mem_stb && i_mem_ack) || (state == ST_DRAIN);
        o_busy        = (state != ST_IDLE) && (state != ST_CAM_RST);
        o_frame_done  = (state == ST_DONE);
    end

    assign o_cam_rst       = cam_rst_active;
    assign o_fifo_activate = activate;
    assign o_overflow      = overflow;
    assign o_dword_count   = dword_count;

endmodule

// File: tb/tb_sf_camera_frame_ctrl.sv
// Directed bench for sf_camera_frame_ctrl with a ppfifo read-side model and
// a memory port with programmable ack delay.
module tb_sf_camera_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_continuous, i_cam_rst_req;
    logic [31:0] i_frame_base;
    logic [23:0] i_frame_dwords;
    logic        o_cam_rst;
    logic        i_fifo_ready;
    logic        o_fifo_activate;
    logic [23:0] i_fifo_size;
    logic        o_fifo_strobe;
    logic [31:0] i_fifo_data;
    logic [31:0] o_mem_addr, o_mem_data;
    logic        o_mem_stb;
    logic        i_mem_ack;
    logic        o_busy, o_frame_done, o_overflow;
    logic [23:0] o_dword_count;

    int checks = 0;
    int failures = 0;

    int blk_q[$];
    bit m_active = 0;
    int m_size, m_blk, m_pos;
    int blk_next = 0;
    int ack_delay = 1;
    int wait_cnt = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int n_strobe, n_drain, n_done, n_act_fall, n_busy_fall, n_cam_hi, n_unstable;
    int stb_run, stb_max;
    logic prev_stb = 0, prev_act = 0, prev_busy = 0;
    logic [31:0] prev_addr = 0, prev_data = 0;
    int b0;

    sf_camera_frame_ctrl #(
        .CAM_RST_CYCLES (10),
        .ADDR_STEP      (4),
        .COUNT_WIDTH    (24)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_continuous    (i_continuous),
        .i_cam_rst_req   (i_cam_rst_req),
        .i_frame_base    (i_frame_base),
        .i_frame_dwords  (i_frame_dwords),
        .o_cam_rst       (o_cam_rst),
        .i_fifo_ready    (i_fifo_ready),
        .o_fifo_activate (o_fifo_activate),
        .i_fifo_size     (i_fifo_size),
        .o_fifo_strobe   (o_fifo_strobe),
        .i_fifo_data     (i_fifo_data),
        .o_mem_addr      (o_mem_addr),
        .o_mem_data      (o_mem_data),
        .o_mem_stb       (o_mem_stb),
        .i_mem_ack       (i_mem_ack),
        .o_busy          (o_busy),
        .o_frame_done    (o_frame_done),
        .o_overflow      (o_overflow),
        .o_dword_count   (o_dword_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input int b, input int p);
        return 32'hA000_0000 | (32'(b) << 8) | 32'(p);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic clearLogs();
        wr_addr.delete();
        wr_data.delete();
        n_strobe = 0; n_drain = 0; n_done = 0; n_act_fall = 0;
        n_busy_fall = 0; n_cam_hi = 0; n_unstable = 0;
        stb_run = 0; stb_max = 0;
    endtask

    // Sample at the falling edge, update the FIFO/memory models, drive after the rising edge
    task automatic stepCycle();
        logic next_ack;
        @(negedge clk);
        if (o_fifo_strobe) begin
            n_strobe++;
            if (!(o_mem_stb && i_mem_ack)) n_drain++;
            if (m_active) m_pos++;
        end
        if (o_mem_stb && i_mem_ack) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_data);
        end
        if (o_mem_stb) begin
            if (prev_stb && (o_mem_addr !== prev_addr || o_mem_data !== prev_data)) n_unstable++;
            stb_run++;
            if (stb_run > stb_max) stb_max = stb_run;
        end else begin
            stb_run = 0;
        end
        if (o_frame_done) n_done++;
        if (prev_act && !o_fifo_activate) n_act_fall++;
        if (prev_busy && !o_busy) n_busy_fall++;
        if (o_cam_rst) n_cam_hi++;
        prev_stb  = o_mem_stb;
        prev_addr = o_mem_addr;
        prev_data = o_mem_data;
        prev_act  = o_fifo_activate;
        prev_busy = o_busy;
        if (!m_active && o_fifo_activate && blk_q.size() > 0) begin
            m_active = 1;
            m_size   = blk_q.pop_front();
            m_blk    = blk_next;
            blk_next++;
            m_pos    = 0;
        end else if (m_active && !o_fifo_activate) begin
            m_active = 0;
        end
        if (o_mem_stb && !i_mem_ack) wait_cnt++;
        else wait_cnt = 0;
        next_ack = o_mem_stb && !i_mem_ack && (wait_cnt >= ack_delay);
        @(posedge clk);
        #1;
        i_fifo_ready  = !m_active && (blk_q.size() > 0);
        i_fifo_size   = m_active ? 24'(m_size) : ((blk_q.size() > 0) ? 24'(blk_q[0]) : 24'd0);
        i_fifo_data   = m_active ? wordOf(m_blk, m_pos) : wordOf(blk_next, 0);
        i_mem_ack     = next_ack;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_cam_rst_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [23:0] dwords, input logic cont,
                                 input logic start, input logic abort, input logic cam_req);
        i_frame_base   = base;
        i_frame_dwords = dwords;
        i_continuous   = cont;
        i_start        = start;
        i_abort        = abort;
        i_cam_rst_req  = cam_req;
        stepCycle();
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_idle"}, 32'(o_busy), 32'h0);
        repeat (2) stepCycle();
    endtask

    task automatic waitStb(input string tag, input int budget);
        int n = 0;
        while (!o_mem_stb && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput({tag, "_stb_seen"}, 32'(o_mem_stb), 32'h1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        i_start = 0; i_abort = 0; i_continuous = 0; i_cam_rst_req = 0;
        i_frame_base = 0; i_frame_dwords = 0;
        i_fifo_ready = 0; i_fifo_size = 0; i_fifo_data = wordOf(0, 0); i_mem_ack = 0;
        clearLogs();
        repeat (3) stepCycle();

        checkOutput("rst_busy", 32'(o_busy), 32'h0);
        checkOutput("rst_stb", 32'(o_mem_stb), 32'h0);
        checkOutput("rst_addr", o_mem_addr, 32'h0);
        checkOutput("rst_data", o_mem_data, 32'h0);
        checkOutput("rst_activate", 32'(o_fifo_activate), 32'h0);
        checkOutput("rst_cam_rst", 32'(o_cam_rst), 32'h0);
        checkOutput("rst_count", 32'(o_dword_count), 32'h0);
        checkOutput("rst_overflow", 32'(o_overflow), 32'h0);
        checkOutput("rst_done", 32'(o_frame_done), 32'h0);
        rst = 1'b0;
        stepCycle();

        // Single 8-dword frame from one 8-dword block
        clearLogs(); ack_delay = 1; blk_q.push_back(8); b0 = blk_next;
        applyStimulus(32'h1000, 24'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        waitIdle("t1", 200);
        checkOutput("t1_writes", 32'(wr_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < wr_addr.size()) begin
                checkOutput($sformatf("t1_addr%0d", i), wr_addr[i], 32'h1000 + 32'(4 * i));
                checkOutput($sformatf("t1_data%0d", i), wr_data[i], wordOf(b0, i));
            end
        end
        checkOutput("t1_strobes", 32'(n_strobe), 32'd8);
        checkOutput("t1_done", 32'(n_done), 32'd1);
        checkOutput("t1_busy_fall", 32'(n_busy_fall), 32'd1);
        checkOutput("t1_overflow", 32'(o_overflow), 32'h0);
        checkOutput("t1_count", 32'(o_dword_count), 32'd8);

        // Frame of 6 from blocks of 4 and 4: two dwords drained
        clearLogs(); blk_q.push_back(4); blk_q.push_back(4); b0 = blk_next;
        applyStimulus(32'h2000, 24'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        waitIdle("t2", 300);
        checkOutput("t2_writes", 32'(wr_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr.size()) begin
                checkOutput($sformatf("t2_addr%0d", i), wr_addr[i], 32'h2000 + 32'(4 * i));
                checkOutput($sformatf("t2_data%0d", i), wr_data[i],
                            (i < 4) ? wordOf(b0, i) : wordOf(b0 + 1, i - 4));
            end
        end
        checkOutput("t2_drained", 32'(n_drain), 32'd2);
        checkOutput("t2_overflow", 32'(o_overflow), 32'h1);
        checkOutput("t2_count", 32'(o_dword_count), 32'd6);
        checkOutput("t2_act_fall", 32'(n_act_fall), 32'd2);
        checkOutput("t2_done", 32'(n_done), 32'd1);

        // Continuous mode: three 4-dword frames, then abort while waiting for a block
        clearLogs(); blk_q.push_back(4); blk_q.push_back(4); blk_q.push_back(4);
        applyStimulus(32'h3000, 24'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        begin
            int n = 0;
            while (n_done < 3 && n < 400) begin
                stepCycle();
                n++;
            end
        end
        repeat (3) stepCycle();
        checkOutput("t3_done", 32'(n_done), 32'd3);
        checkOutput("t3_busy", 32'(o_busy), 32'h1);
        checkOutput("t3_busy_fall", 32'(n_busy_fall), 32'd0);
        checkOutput("t3_count_clr", 32'(o_dword_count), 32'd0);
        checkOutput("t3_writes", 32'(wr_addr.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < wr_addr.size())
                checkOutput($sformatf("t3_addr%0d", i), wr_addr[i], 32'h3000 + 32'(4 * (i % 4)));
        end
        applyStimulus(32'h3000, 24'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        waitIdle("t3", 50);
        checkOutput("t3_done_after_abort", 32'(n_done), 32'd3);

        // Slow ack: strobe held 5 wait cycles plus the ack cycle, one FIFO strobe
        clearLogs(); ack_delay = 5; blk_q.push_back(1);
        applyStimulus(32'h4000, 24'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        waitIdle("t4", 100);
        checkOutput("t4_stb_cycles", 32'(stb_max), 32'd6);
        checkOutput("t4_unstable", 32'(n_unstable), 32'd0);
        checkOutput("t4_strobes", 32'(n_strobe), 32'd1);
        checkOutput("t4_writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) checkOutput("t4_addr", wr_addr[0], 32'h4000);

        // Zero-length frame request is ignored
        clearLogs(); ack_delay = 1;
        applyStimulus(32'h6000, 24'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) stepCycle();
        checkOutput("t0_busy", 32'(o_busy), 32'h0);

        // Abort while a write waits for its ack
        clearLogs(); ack_delay = 8; blk_q.push_back(4);
        applyStimulus(32'h5000, 24'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        waitStb("t5", 50);
        applyStimulus(32'h5000, 24'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        waitIdle("t5", 100);
        checkOutput("t5_writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) checkOutput("t5_addr", wr_addr[0], 32'h5000);
        checkOutput("t5_strobes", 32'(n_strobe), 32'd1);
        checkOutput("t5_done", 32'(n_done), 32'd0);
        checkOutput("t5_act_fall", 32'(n_act_fall), 32'd1);

        // Start and abort together: abort wins
        clearLogs(); ack_delay = 1; blk_q.push_back(4);
        applyStimulus(32'h5100, 24'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t5b_busy", 32'(o_busy), 32'h0);
        repeat (5) stepCycle();
        checkOutput("t5b_activate", 32'(o_fifo_activate), 32'h0);
        checkOutput("t5b_writes", 32'(wr_addr.size()), 32'd0);
        blk_q.delete();
        stepCycle();

        // Camera reset for 10 cycles with a start attempt during it
        clearLogs(); blk_q.push_back(4);
        applyStimulus(32'h0, 24'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) stepCycle();
        checkOutput("t6_cam_rst_on", 32'(o_cam_rst), 32'h1);
        applyStimulus(32'h8000, 24'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_busy_during", 32'(o_busy), 32'h0);
        repeat (20) stepCycle();
        checkOutput("t6_cam_hi", 32'(n_cam_hi), 32'd10);
        checkOutput("t6_cam_rst_off", 32'(o_cam_rst), 32'h0);
        checkOutput("t6_busy", 32'(o_busy), 32'h0);
        checkOutput("t6_writes", 32'(wr_addr.size()), 32'd0);
        blk_q.delete();
        stepCycle();

        // Reset in the middle of a pending write
        clearLogs(); ack_delay = 8; blk_q.push_back(4);
        applyStimulus(32'h7000, 24'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        waitStb("t7", 50);
        rst = 1'b1;
        stepCycle();
        checkOutput("t7_stb", 32'(o_mem_stb), 32'h0);
        checkOutput("t7_busy", 32'(o_busy), 32'h0);
        checkOutput("t7_activate", 32'(o_fifo_activate), 32'h0);
        checkOutput("t7_count", 32'(o_dword_count), 32'h0);
        rst = 1'b0;
        blk_q.delete();
        repeat (3) stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
